// File: rtl/gstsnd_pkg.sv
// gstsnd_pkg: register map, control-bit positions and sequencer states shared
// by the STE DMA-sound frame sequencer and its address counter.
package gstsnd_pkg;

  localparam logic [5:0] SND_CTRL    = 6'h00;
  localparam logic [5:0] SND_START_H = 6'h01;
  localparam logic [5:0] SND_START_M = 6'h02;
  localparam logic [5:0] SND_START_L = 6'h03;
  localparam logic [5:0] SND_CNT_H   = 6'h04;
  localparam logic [5:0] SND_CNT_M   = 6'h05;
  localparam logic [5:0] SND_CNT_L   = 6'h06;
  localparam logic [5:0] SND_END_H   = 6'h07;
  localparam logic [5:0] SND_END_M   = 6'h08;
  localparam logic [5:0] SND_END_L   = 6'h09;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_LOOP = 1;

  typedef enum logic [1:0] {IDLE, WAIT, LOAD, END_CHK} snd_state_e;

  // Byte lane of a 24-bit byte address: 0=hi, 1=mid, 2=lo.
  function automatic logic [7:0] addr_byte(input logic [23:0] v, input logic [1:0] lane);
    logic [7:0] r;
    case (lane)
      2'd0:    r = v[23:16];
      2'd1:    r = v[15:8];
      default: r = v[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gstsnd_addr_cnt.sv
// gstsnd_addr_cnt: sound fetch word-address counter with its frame-end latch.
// Load takes start and end together; eq_o flags counter == latched end.
module gstsnd_addr_cnt
  import gstsnd_pkg::*;
#(
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W-1:0] end_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              eq_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] fend_q, fend_d;

  // A reload outranks an increment landing on the same edge.
  always_comb begin
    cnt_d  = cnt_q;
    fend_d = fend_q;
    if (load_i) begin
      cnt_d  = start_i;
      fend_d = end_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      fend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fend_q <= fend_d;
    end
  end

  assign cnt_o = cnt_q;
  assign eq_o  = (cnt_q == fend_q);

endmodule

// File: rtl/gstsnd_dma_ctrl.sv
// gstsnd_dma_ctrl: STE DMA-sound frame sequencer. Holds the FF8900-FF8913 registers,
// answers SREQ in granted bus slots with SLOAD_N strobes and signals frame end on SINT.
module gstsnd_dma_ctrl
  import gstsnd_pkg::*;
#(
  parameter int LOAD_CYC = 4,
  parameter int ADDR_W   = 23
) (
  input  logic              clk32,
  input  logic              res,
  input  logic              CS,
  input  logic [5:0]        A,
  input  logic [7:0]        DIN,
  input  logic              RW,
  output logic [7:0]        DOUT,
  input  logic              SREQ,
  input  logic              SLOT,
  output logic [ADDR_W-1:0] SADDR,
  output logic              SLOAD_N,
  output logic              SACTIVE,
  output logic              SINT
);

  localparam int              LC_W    = (LOAD_CYC > 2) ? $clog2(LOAD_CYC) : 1;
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOAD_CYC - 1);

  snd_state_e      state_q, state_d;
  logic [LC_W-1:0] load_cnt_q, load_cnt_d;
  logic            enable_q, enable_d;
  logic            loop_q, loop_d;
  logic [23:0]     start_q, start_d;
  logic [23:0]     end_q, end_d;
  logic            zero_q, zero_d;
  logic            sint_q, sint_d;

  logic              wr, wr_ctrl, en_rise;
  logic              cnt_load, cnt_inc, cnt_eq;
  logic              reload, end_clear;
  logic [ADDR_W-1:0] start_w, end_w;
  logic [23:0]       cnt_byte;

  assign wr       = CS & ~RW;
  assign wr_ctrl  = wr && (A == SND_CTRL);
  assign en_rise  = wr_ctrl & DIN[CTRL_EN] & ~enable_q;
  assign start_w  = start_q[ADDR_W:1];
  assign end_w    = end_q[ADDR_W:1];
  assign cnt_load = en_rise | reload;
  // An empty or inverted frame is remembered for one cycle and retired as a lone SINT.
  assign zero_d   = en_rise && (start_w >= end_w);

  gstsnd_addr_cnt #(
    .ADDR_W(ADDR_W)
  ) u_addr_cnt (
    .clk    (clk32),
    .rst    (res),
    .load_i (cnt_load),
    .start_i(start_w),
    .end_i  (end_w),
    .inc_i  (cnt_inc),
    .cnt_o  (SADDR),
    .eq_o   (cnt_eq)
  );

  // CPU register writes; a ctrl write overrides the sequencer clearing enable.
  always_comb begin
    start_d  = start_q;
    end_d    = end_q;
    loop_d   = loop_q;
    enable_d = enable_q;
    if (end_clear) begin
      enable_d = 1'b0;
    end
    if (wr) begin
      case (A)
        SND_CTRL: begin
          enable_d = DIN[CTRL_EN];
          loop_d   = DIN[CTRL_LOOP];
        end
        SND_START_H: start_d[23:16] = DIN;
        SND_START_M: start_d[15:8]  = DIN;
        SND_START_L: start_d[7:0]   = {DIN[7:1], 1'b0};
        SND_END_H:   end_d[23:16]   = DIN;
        SND_END_M:   end_d[15:8]    = DIN;
        SND_END_L:   end_d[7:0]     = DIN;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    cnt_inc    = 1'b0;
    reload     = 1'b0;
    end_clear  = 1'b0;
    sint_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_q && SREQ && !cnt_eq && !zero_q) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!enable_q || !SREQ) begin
          state_d = IDLE;
        end else if (SLOT) begin
          state_d    = LOAD;
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        // The strobe always runs its full width, even if enable drops meanwhile.
        if (load_cnt_q == LC_LAST) begin
          cnt_inc = 1'b1;
          state_d = END_CHK;
        end else begin
          load_cnt_d = load_cnt_q + LC_W'(1);
        end
      end
      END_CHK: begin
        state_d = IDLE;
        if (enable_q && cnt_eq) begin
          sint_d = 1'b1;
          if (loop_q) begin
            reload = 1'b1;
          end else begin
            end_clear = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (zero_q) begin
      sint_d    = 1'b1;
      end_clear = 1'b1;
    end
  end

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      enable_q   <= 1'b0;
      loop_q     <= 1'b0;
      start_q    <= '0;
      end_q      <= '0;
      zero_q     <= 1'b0;
      sint_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      enable_q   <= enable_d;
      loop_q     <= loop_d;
      start_q    <= start_d;
      end_q      <= end_d;
      zero_q     <= zero_d;
      sint_q     <= sint_d;
    end
  end

  // Decoded straight from the state register so an async reset releases the strobe at once.
  assign SLOAD_N = (state_q != LOAD);
  assign SACTIVE = enable_q;
  assign SINT    = sint_q;

  always_comb begin
    cnt_byte             = '0;
    cnt_byte[ADDR_W:1]   = SADDR;
    DOUT                 = '0;
    if (CS) begin
      case (A)
        SND_CTRL:    DOUT = {6'b0, loop_q, enable_q};
        SND_START_H: DOUT = addr_byte(start_q, 2'd0);
        SND_START_M: DOUT = addr_byte(start_q, 2'd1);
        SND_START_L: DOUT = addr_byte(start_q, 2'd2);
        SND_CNT_H:   DOUT = addr_byte(cnt_byte, 2'd0);
        SND_CNT_M:   DOUT = addr_byte(cnt_byte, 2'd1);
        SND_CNT_L:   DOUT = addr_byte(cnt_byte, 2'd2);
        SND_END_H:   DOUT = addr_byte(end_q, 2'd0);
        SND_END_M:   DOUT = addr_byte(end_q, 2'd1);
        SND_END_L:   DOUT = addr_byte(end_q, 2'd2);
        default:     DOUT = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gstsnd_dma_ctrl.sv
// tb_gstsnd_dma_ctrl: directed frames with a scoreboard of expected strobes and SINT pulses,
// consumed by an independent monitor on the falling clock edge.
module tb_gstsnd_dma_ctrl;
  import gstsnd_pkg::*;

  localparam int LOAD_CYC  = 4;
  localparam int ADDR_W    = 23;
  localparam int EV_STROBE = 0;
  localparam int EV_SINT   = 1;

  logic              clk32 = 1'b0;
  logic              res   = 1'b1;
  logic              CS    = 1'b0;
  logic [5:0]        A     = '0;
  logic [7:0]        DIN   = '0;
  logic              RW    = 1'b1;
  logic [7:0]        DOUT;
  logic              SREQ  = 1'b0;
  logic              SLOT  = 1'b0;
  logic [ADDR_W-1:0] SADDR;
  logic              SLOAD_N;
  logic              SACTIVE;
  logic              SINT;

  always #5 clk32 = ~clk32;

  gstsnd_dma_ctrl #(
    .LOAD_CYC(LOAD_CYC),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk32  (clk32),
    .res    (res),
    .CS     (CS),
    .A      (A),
    .DIN    (DIN),
    .RW     (RW),
    .DOUT   (DOUT),
    .SREQ   (SREQ),
    .SLOT   (SLOT),
    .SADDR  (SADDR),
    .SLOAD_N(SLOAD_N),
    .SACTIVE(SACTIVE),
    .SINT   (SINT)
  );

  typedef struct {
    int          kind;
    logic [22:0] addr;
    int          width;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [22:0] addr, input int width, input bit stable);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h width %0d, expected no event", kind, addr, width);
    end else begin
      e = exp_q.pop_front();
      $display("event kind=%0d addr=0x%0h width=%0d (expected kind=%0d addr=0x%0h)", kind, addr, width, e.kind, e.addr);
      check("event_kind", kind, e.kind);
      if (e.kind == EV_STROBE) begin
        check("strobe_addr", addr, e.addr);
        check("strobe_width", width, e.width);
        check("saddr_stable", stable, 1);
      end
    end
  endtask

  // SLOT: one-cycle pulse every 64 clocks, changed on the falling edge.
  int slot_div = 0;
  initial begin
    forever begin
      @(negedge clk32);
      if (slot_div == 63) begin
        SLOT     = 1'b1;
        slot_div = 0;
      end else begin
        SLOT = 1'b0;
        slot_div++;
      end
    end
  end

  bit          mon_in     = 1'b0;
  int          mon_w      = 0;
  logic [22:0] mon_a      = '0;
  bit          mon_stable = 1'b1;
  initial begin
    forever begin
      @(negedge clk32);
      if (res) begin
        mon_in = 1'b0;
      end else begin
        if (!SLOAD_N) begin
          if (!mon_in) begin
            mon_in     = 1'b1;
            mon_w      = 0;
            mon_a      = SADDR;
            mon_stable = 1'b1;
          end
          mon_w++;
          if (SADDR !== mon_a) mon_stable = 1'b0;
        end else if (mon_in) begin
          mon_in = 1'b0;
          pop_cmp(EV_STROBE, mon_a, mon_w, mon_stable);
        end
        if (SINT) pop_cmp(EV_SINT, SADDR, 0, 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
    tick();
    CS = 1'b1; RW = 1'b0; A = a; DIN = d;
    tick();
    CS = 1'b0; RW = 1'b1;
  endtask

  task automatic cpu_rd(input string name, input logic [5:0] a, input logic [7:0] expv);
    CS = 1'b1; RW = 1'b1; A = a;
    #1;
    check(name, DOUT, expv);
    CS = 1'b0;
  endtask

  task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
    logic [23:0] sv;
    logic [23:0] ev;
    sv = s;
    ev = e;
    cpu_wr(SND_START_H, sv[23:16]);
    cpu_wr(SND_START_M, sv[15:8]);
    cpu_wr(SND_START_L, sv[7:0]);
    cpu_wr(SND_END_H, ev[23:16]);
    cpu_wr(SND_END_M, ev[15:8]);
    cpu_wr(SND_END_L, ev[7:0]);
  endtask

  task automatic push_strobe(input logic [22:0] a);
    ev_t e;
    e.kind  = EV_STROBE;
    e.addr  = a;
    e.width = LOAD_CYC;
    exp_q.push_back(e);
  endtask

  task automatic push_sint();
    ev_t e;
    e.kind  = EV_SINT;
    e.addr  = '0;
    e.width = 0;
    exp_q.push_back(e);
  endtask

  task automatic wait_qsize(input string name, input int sz, input int maxc);
    int n = 0;
    while (exp_q.size() > sz && n < maxc) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), sz);
  endtask

  task automatic wait_inactive(input string name, input int maxc);
    int n = 0;
    while (SACTIVE && n < maxc) begin
      tick();
      n++;
    end
    check(name, SACTIVE, 0);
  endtask

  task automatic wait_sload(input string name, input int maxc);
    int n = 0;
    while (SLOAD_N && n < maxc) begin
      tick();
      n++;
    end
    check(name, SLOAD_N, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int slots;
    int n;

    // Reset state
    repeat (3) tick();
    check("rst_sload_n", SLOAD_N, 1);
    check("rst_sactive", SACTIVE, 0);
    check("rst_sint", SINT, 0);
    check("rst_saddr", SADDR, 0);
    cpu_rd("rst_ctrl", SND_CTRL, 8'h00);
    res = 1'b0;
    tick();
    cpu_rd("rst_start_h", SND_START_H, 8'h00);

    // Single frame, no loop
    SREQ = 1'b1;
    set_frame(24'h010000, 24'h010008);
    cpu_rd("start_h", SND_START_H, 8'h01);
    cpu_rd("end_l", SND_END_L, 8'h08);
    for (int i = 0; i < 4; i++) push_strobe(23'h8000 + 23'(i));
    push_sint();
    cpu_wr(SND_CTRL, 8'h01);
    wait_qsize("single_drain", 0, 64 * 8);
    wait_inactive("single_sactive", 8);
    cpu_rd("single_ctrl", SND_CTRL, 8'h00);
    cpu_rd("single_cnt_h", SND_CNT_H, 8'h01);
    cpu_rd("single_cnt_m", SND_CNT_M, 8'h00);
    cpu_rd("single_cnt_l", SND_CNT_L, 8'h08);

    // Loop: end rewritten during frame 1 applies to frame 2
    for (int i = 0; i < 4; i++) push_strobe(23'h8000 + 23'(i));
    push_sint();
    push_strobe(23'h8000);
    push_strobe(23'h8001);
    push_sint();
    cpu_wr(SND_CTRL, 8'h03);
    cpu_wr(SND_END_L, 8'h04);
    wait_qsize("loop_frame1", 3, 64 * 8);
    cpu_wr(SND_CTRL, 8'h01);
    wait_qsize("loop_drain", 0, 64 * 8);
    wait_inactive("loop_sactive", 8);
    cpu_rd("loop_ctrl", SND_CTRL, 8'h00);

    // Back-pressure after the first fetch
    cpu_wr(SND_END_L, 8'h08);
    for (int i = 0; i < 4; i++) push_strobe(23'h8000 + 23'(i));
    push_sint();
    cpu_wr(SND_CTRL, 8'h01);
    wait_qsize("bp_first", 4, 64 * 3);
    SREQ  = 1'b0;
    slots = 0;
    n     = 0;
    while (slots < 3 && n < 64 * 5) begin
      tick();
      if (SLOT) slots++;
      n++;
    end
    check("bp_slots_seen", slots, 3);
    check("bp_no_strobe", exp_q.size(), 4);
    check("bp_saddr", SADDR, 23'h8001);
    cpu_rd("bp_cnt_l", SND_CNT_L, 8'h02);
    SREQ = 1'b1;
    wait_qsize("bp_drain", 0, 64 * 6);
    wait_inactive("bp_sactive", 8);

    // Disable during the second strobe
    push_strobe(23'h8000);
    push_strobe(23'h8001);
    cpu_wr(SND_CTRL, 8'h01);
    wait_qsize("dis_first", 1, 64 * 3);
    wait_sload("dis_second_start", 64 * 3);
    cpu_wr(SND_CTRL, 8'h00);
    wait_qsize("dis_drain", 0, 64 * 2);
    repeat (150) tick();
    check("dis_sactive", SACTIVE, 0);
    cpu_rd("dis_cnt_h", SND_CNT_H, 8'h01);
    cpu_rd("dis_cnt_l", SND_CNT_L, 8'h04);

    // Zero-length frame with loop set
    set_frame(24'h020000, 24'h020000);
    push_sint();
    cpu_wr(SND_CTRL, 8'h03);
    wait_qsize("zero_sint", 0, 20);
    repeat (150) tick();
    cpu_rd("zero_ctrl", SND_CTRL, 8'h02);
    check("zero_sactive", SACTIVE, 0);
    cpu_rd("zero_cnt_h", SND_CNT_H, 8'h02);

    // Async reset during a strobe
    set_frame(24'h010000, 24'h010008);
    cpu_wr(SND_CTRL, 8'h01);
    wait_sload("rst_load_start", 64 * 2);
    #2;
    res = 1'b1;
    #1;
    check("rst_mid_sload_n", SLOAD_N, 1);
    check("rst_mid_sactive", SACTIVE, 0);
    check("rst_mid_saddr", SADDR, 0);
    tick();
    cpu_rd("rst_mid_ctrl", SND_CTRL, 8'h00);
    cpu_rd("rst_mid_end_l", SND_END_L, 8'h00);
    tick();
    res = 1'b0;
    repeat (4) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
